// File: rtl/nubus_slave_mem_pkg.sv
// rtl/nubus_slave_mem_pkg.sv - shared types and constants for the NuBus slave memory engine
package nubus_pkg;

  // Transaction engine states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_MEM   = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Status codes returned on TM during ACK
  localparam logic [1:0] STATUS_COMPLETE = 2'b00;
  localparam logic [1:0] STATUS_ERROR    = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'b10;

  // Slot space occupies addresses Fsxx_xxxx
  localparam logic [3:0] SLOT_SPACE_PREFIX = 4'hF;

  // Raw (active-low) TM line meanings
  localparam logic TM1N_READ = 1'b1;
  localparam logic TM0N_WORD = 1'b1;

  // One-hot byte strobe for a byte transfer in the given lane
  function automatic logic [3:0] byte_lane_strobe(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/nubus_slave_mem_if.sv
// rtl/nubus_slave_mem_if.sv - bus-side and memory-side signal bundle for nubus_slave_mem
interface nubus_slave_mem_if;
  logic [3:0]  slot_id;
  logic        start;
  logic        ack;
  logic        tm1n;
  logic        tm0n;
  logic [31:0] ad_in;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        ack_out;
  logic [1:0]  status;
  logic        myslot;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_write;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // The transaction engine
  modport slave (
    input  slot_id, start, ack, tm1n, tm0n, ad_in, mem_rdata, mem_ready,
    output ad_out, ad_oe, ack_out, status, myslot,
           mem_addr, mem_wdata, mem_wstrb, mem_write, mem_valid
  );

  // Bus and memory side driving the engine
  modport master (
    output slot_id, start, ack, tm1n, tm0n, ad_in, mem_rdata, mem_ready,
    input  ad_out, ad_oe, ack_out, status, myslot,
           mem_addr, mem_wdata, mem_wstrb, mem_write, mem_valid
  );
endinterface

// File: rtl/nubus_slave_mem_lane_steer.sv
// rtl/nubus_slave_mem_lane_steer.sv - maps TM0 and address low bits to byte strobes
module nubus_lane_steer
  import nubus_pkg::*;
(
  input  logic       i_tm0n,
  input  logic [1:0] i_ad_lo,
  output logic [3:0] o_wstrb,
  output logic       o_misaligned
);

  // Word transfers use all lanes and must be aligned; byte transfers pick one lane
  always_comb begin
    o_wstrb      = 4'b0000;
    o_misaligned = 1'b0;
    if (i_tm0n == TM0N_WORD) begin
      o_wstrb      = 4'b1111;
      o_misaligned = (i_ad_lo != 2'b00);
    end else begin
      o_wstrb = byte_lane_strobe(i_ad_lo);
    end
  end

endmodule

// File: rtl/nubus_slave_mem.sv
// rtl/nubus_slave_mem.sv - NuBus slave memory transaction engine (optional timeout: NUBUS_SLAVE_TIMEOUT_EN)
module nubus_slave_mem
  import nubus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset,
  nubus_slave_mem_if.slave bus
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      r_state;
  logic [31:0] r_ad_out;
  logic        r_ad_oe;
  logic        r_ack_out;
  logic [1:0]  r_status;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        r_mem_write;
  logic        r_mem_valid;

  logic [3:0]  w_wstrb;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_is_read;

`ifdef NUBUS_SLAVE_TIMEOUT_EN
  localparam logic [7:0] LP_TMO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] r_tmo_cnt;
  logic [7:0] w_tmo_next;
  logic       w_tmo_hit;
  assign w_tmo_next = r_tmo_cnt + 8'd1;
  assign w_tmo_hit  = (w_tmo_next == LP_TMO_LIMIT);
`endif

  nubus_lane_steer u_lane_steer (
    .i_tm0n       (bus.tm0n),
    .i_ad_lo      (bus.ad_in[1:0]),
    .o_wstrb      (w_wstrb),
    .o_misaligned (w_misaligned)
  );

  assign bus.myslot = bus.start
                    & (bus.ad_in[31:28] == SLOT_SPACE_PREFIX)
                    & (bus.ad_in[27:24] == bus.slot_id);

  assign w_accept  = bus.start & ~bus.ack & bus.myslot;
  assign w_is_read = (bus.tm1n == TM1N_READ);

  assign bus.ad_out    = r_ad_out;
  assign bus.ad_oe     = r_ad_oe;
  assign bus.ack_out   = r_ack_out;
  assign bus.status    = r_status;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_valid = r_mem_valid;

  // Transaction FSM with all bus and memory outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ad_out    <= 32'd0;
      r_ad_oe     <= 1'b0;
      r_ack_out   <= 1'b0;
      r_status    <= STATUS_COMPLETE;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_mem_write <= 1'b0;
      r_mem_valid <= 1'b0;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
      r_tmo_cnt   <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mem_addr  <= {bus.ad_in[31:2], 2'b00};
            r_mem_wstrb <= w_wstrb;
            r_mem_write <= ~w_is_read;
            if (w_misaligned) begin
              r_ack_out <= 1'b1;
              r_status  <= STATUS_ERROR;
              r_ad_oe   <= 1'b0;
              r_state   <= ST_ACK;
            end else if (!w_is_read) begin
              r_state <= ST_WDATA;
            end else begin
              r_mem_valid <= 1'b1;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
              r_tmo_cnt   <= 8'd0;
`endif
              r_state     <= ST_MEM;
            end
          end
        end
        ST_WDATA: begin
          if (bus.ack) begin
            r_state <= ST_IDLE;
          end else begin
            r_mem_wdata <= bus.ad_in;
            r_mem_valid <= 1'b1;
`ifdef NUBUS_SLAVE_TIMEOUT_EN
            r_tmo_cnt   <= 8'd0;
`endif
            r_state     <= ST_MEM;
          end
        end
        ST_MEM: begin
          // Another agent's ACK ends the bus cycle, so the request is abandoned
          if (bus.ack) begin
            r_mem_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (bus.mem_ready) begin
            r_mem_valid <= 1'b0;
            if (!r_mem_write) begin
              r_ad_out <= bus.mem_rdata;
            end
            r_ad_oe   <= ~r_mem_write;
            r_ack_out <= 1'b1;
            r_status  <= STATUS_COMPLETE;
            r_state   <= ST_ACK;
          end
`ifdef NUBUS_SLAVE_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_mem_valid <= 1'b0;
            r_ad_oe     <= 1'b0;
            r_ack_out   <= 1'b1;
            r_status    <= STATUS_TIMEOUT;
            r_state     <= ST_ACK;
          end else begin
            r_tmo_cnt <= w_tmo_next;
          end
`endif
        end
        ST_ACK: begin
          r_ack_out <= 1'b0;
          r_ad_oe   <= 1'b0;
          r_status  <= STATUS_COMPLETE;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nubus_slave_mem.sv
// tb/tb_nubus_slave_mem.sv - self-checking bench for nubus_slave_mem
module tb_nubus_slave_mem;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nubus_slave_mem_if bus();

  nubus_slave_mem #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Observations gathered by run_txn
  int          t_ack_cyc;
  int          t_valid_cyc;
  int          t_nvalid;
  logic [1:0]  t_status;
  logic        t_oe;
  logic        t_ack_next;
  logic        t_stable;
  logic        t_write;
  logic [31:0] t_adout;
  logic [31:0] t_maddr;
  logic [31:0] t_wdata;
  logic [3:0]  t_wstrb;

  // Issue one bus transaction; memory answers after `waits` valid cycles
  task automatic run_txn(input logic [31:0] addr, input logic tm1n, input logic tm0n,
                         input logic [31:0] data, input int waits);
    t_ack_cyc = 0; t_valid_cyc = 0; t_nvalid = 0; t_stable = 1'b1;
    t_status = 2'b11; t_oe = 1'bx; t_ack_next = 1'bx; t_write = 1'bx;
    t_adout = 32'hx; t_maddr = 32'hx; t_wdata = 32'hx; t_wstrb = 4'hx;
    @(negedge clk);
    bus.start = 1'b1; bus.ad_in = addr; bus.tm1n = tm1n; bus.tm0n = tm0n;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.tm1n = 1'b1; bus.tm0n = 1'b1;
      bus.ad_in = (c == 1) ? data : ~data;
      bus.mem_ready = 1'b0; bus.mem_rdata = ~data;
      if (bus.ack_out) begin
        t_ack_cyc = c; t_status = bus.status; t_oe = bus.ad_oe; t_adout = bus.ad_out;
        break;
      end
      if (bus.mem_valid) begin
        if (t_valid_cyc == 0) begin
          t_valid_cyc = c; t_maddr = bus.mem_addr; t_wstrb = bus.mem_wstrb;
          t_write = bus.mem_write; t_wdata = bus.mem_wdata;
        end else if (bus.mem_addr !== t_maddr || bus.mem_wstrb !== t_wstrb ||
                     bus.mem_write !== t_write || bus.mem_wdata !== t_wdata) begin
          t_stable = 1'b0;
        end
        t_nvalid++;
        if (c - t_valid_cyc == waits) begin
          bus.mem_ready = 1'b1; bus.mem_rdata = data;
        end
      end
    end
    @(negedge clk);
    t_ack_next = bus.ack_out;
    bus.ad_in = 32'd0;
  endtask

  task automatic check_result(input string tag, input logic tm1n, input logic [31:0] data,
                              input int e_valid, input int e_nvalid, input int e_ack,
                              input logic [1:0] e_status, input logic e_oe,
                              input logic [3:0] e_wstrb, input logic [31:0] e_maddr);
    chk({tag, ".ack_cyc"}, t_ack_cyc, e_ack);
    chk({tag, ".status"}, {30'd0, t_status}, {30'd0, e_status});
    chk({tag, ".ad_oe"}, {31'd0, t_oe}, {31'd0, e_oe});
    chk({tag, ".ack_one_cycle"}, {31'd0, t_ack_next}, 32'd0);
    chk({tag, ".valid_cyc"}, t_valid_cyc, e_valid);
    chk({tag, ".nvalid"}, t_nvalid, e_nvalid);
    if (e_valid != 0) begin
      chk({tag, ".mem_addr"}, t_maddr, e_maddr);
      chk({tag, ".mem_wstrb"}, {28'd0, t_wstrb}, {28'd0, e_wstrb});
      chk({tag, ".mem_write"}, {31'd0, t_write}, {31'd0, ~tm1n});
      chk({tag, ".stable"}, {31'd0, t_stable}, 32'd1);
      if (!tm1n) chk({tag, ".mem_wdata"}, t_wdata, data);
    end
    if (e_oe) chk({tag, ".ad_out"}, t_adout, data);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        tm1n;
    logic        tm0n;
    logic [31:0] data;
    int          waits;
    int          e_valid;
    int          e_nvalid;
    int          e_ack;
    logic [1:0]  e_status;
    logic        e_oe;
    logic [3:0]  e_wstrb;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] addr, data;
    logic        tm1n, tm0n, mis, oe;
    int          waits, e_valid, e_nvalid, e_ack;
    logic        flag;

    tbl[0] = '{32'hF900_0010, 1'b1, 1'b1, 32'hDEAD_BEEF, 0, 1, 1, 2, 2'b00, 1'b1, 4'hF, 32'hF900_0010};
    tbl[1] = '{32'hF900_0003, 1'b0, 1'b0, 32'hA500_0000, 0, 2, 1, 3, 2'b00, 1'b0, 4'h8, 32'hF900_0000};
    tbl[2] = '{32'hF900_0002, 1'b1, 1'b1, 32'hCAFE_F00D, 0, 0, 0, 1, 2'b01, 1'b0, 4'h0, 32'h0};
    tbl[3] = '{32'hF900_0100, 1'b0, 1'b1, 32'h1234_5678, 3, 2, 4, 6, 2'b00, 1'b0, 4'hF, 32'hF900_0100};
    tbl[4] = '{32'hF900_0005, 1'b1, 1'b0, 32'h0000_AB00, 2, 1, 3, 4, 2'b00, 1'b1, 4'h2, 32'hF900_0004};
    tbl[5] = '{32'hF900_0001, 1'b0, 1'b1, 32'h1111_1111, 0, 0, 0, 1, 2'b01, 1'b0, 4'h0, 32'h0};

    bus.slot_id = 4'd9; bus.start = 1'b0; bus.ack = 1'b0; bus.tm1n = 1'b1; bus.tm0n = 1'b1;
    bus.ad_in = 32'd0; bus.mem_rdata = 32'd0; bus.mem_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.ctl", {22'd0, bus.ad_oe, bus.ack_out, bus.status, bus.mem_wstrb, bus.mem_write, bus.mem_valid}, 32'd0);
    chk("reset.ad_out", bus.ad_out, 32'd0);
    chk("reset.mem_addr", bus.mem_addr, 32'd0);
    chk("reset.mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table of directed transactions
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].addr, tbl[i].tm1n, tbl[i].tm0n, tbl[i].data, tbl[i].waits);
      check_result($sformatf("vec%0d", i), tbl[i].tm1n, tbl[i].data, tbl[i].e_valid,
                   tbl[i].e_nvalid, tbl[i].e_ack, tbl[i].e_status, tbl[i].e_oe,
                   tbl[i].e_wstrb, tbl[i].e_maddr);
    end

    // Address decode: foreign slot space, wrong slot number, and own slot held off by ACK
    @(negedge clk);
    bus.start = 1'b1; bus.ad_in = 32'hA000_0000;
    #1 chk("decode.foreign", {31'd0, bus.myslot}, 32'd0);
    bus.ad_in = 32'hF800_0000;
    #1 chk("decode.other_slot", {31'd0, bus.myslot}, 32'd0);
    bus.ad_in = 32'hF900_0000; bus.ack = 1'b1;
    #1 chk("decode.own_slot", {31'd0, bus.myslot}, 32'd1);
    bus.ad_in = 32'hA000_0000; bus.ack = 1'b0;
    flag = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.mem_valid || bus.ack_out || bus.ad_oe) flag = 1'b1;
    end
    chk("decode.no_activity", {31'd0, flag}, 32'd0);

    // Foreign ACK during MEM aborts without acknowledging
    @(negedge clk);
    bus.start = 1'b1; bus.ad_in = 32'hF900_0020; bus.tm1n = 1'b1; bus.tm0n = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort.valid_before", {31'd0, bus.mem_valid}, 32'd1);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("abort.valid_dropped", {31'd0, bus.mem_valid}, 32'd0);
    flag = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.ack_out || bus.mem_valid) flag = 1'b1;
    end
    chk("abort.no_ack", {31'd0, flag}, 32'd0);

    // Timeout behaviour with memory never answering
`ifdef NUBUS_SLAVE_TIMEOUT_EN
    run_txn(32'hF900_0040, 1'b1, 1'b1, 32'h5555_AAAA, 99);
    check_result("timeout", 1'b1, 32'h5555_AAAA, 1, 4, 5, 2'b10, 1'b0, 4'hF, 32'hF900_0040);
`else
    run_txn(32'hF900_0040, 1'b1, 1'b1, 32'h5555_AAAA, 10);
    check_result("long_wait", 1'b1, 32'h5555_AAAA, 1, 11, 12, 2'b00, 1'b1, 4'hF, 32'hF900_0040);
`endif

    // Reset while a request is outstanding, then a clean transaction
    @(negedge clk);
    bus.start = 1'b1; bus.ad_in = 32'hF900_0080; bus.tm1n = 1'b1; bus.tm0n = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_mid.valid_before", {31'd0, bus.mem_valid}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("rst_mid.ctl", {22'd0, bus.ad_oe, bus.ack_out, bus.status, bus.mem_wstrb, bus.mem_write, bus.mem_valid}, 32'd0);
    chk("rst_mid.mem_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_txn(32'hF900_0084, 1'b1, 1'b1, 32'h0BAD_CAFE, 1);
    check_result("after_rst", 1'b1, 32'h0BAD_CAFE, 1, 2, 3, 2'b00, 1'b1, 4'hF, 32'hF900_0084);

    // Random transactions against a rule-based model
    for (int n = 0; n < 30; n++) begin
      addr  = {8'hF9, 24'($urandom)};
      data  = $urandom;
      tm1n  = 1'($urandom_range(0, 1));
      tm0n  = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 3);
      mis      = tm0n && (addr[1:0] != 2'b00);
      e_valid  = mis ? 0 : (tm1n ? 1 : 2);
      e_nvalid = mis ? 0 : waits + 1;
      e_ack    = mis ? 1 : e_valid + waits + 1;
      oe       = !mis && tm1n;
      run_txn(addr, tm1n, tm0n, data, waits);
      check_result($sformatf("rnd%0d", n), tm1n, data, e_valid, e_nvalid, e_ack,
                   mis ? 2'b01 : 2'b00, oe,
                   tm0n ? 4'hF : (4'b0001 << addr[1:0]), addr & 32'hFFFF_FFFC);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
